// File: rtl/pe_vector_sequencer_if.sv
// pe_vector_sequencer_if: operand stream, PE lane and result stream bundle for the vector sequencer
interface pe_vector_sequencer_if #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_LEN = 8
);
  logic [WIDTH_LEN-1:0] cfg_len_i;
  logic in_valid_i;
  logic in_ready_o;
  logic [WIDTH_DATA-1:0] in_a_i;
  logic [WIDTH_DATA-1:0] in_b_i;
  logic [WIDTH_DATA-1:0] pe_data_a_o;
  logic [WIDTH_DATA-1:0] pe_data_b_o;
  logic pe_format_en_o;
  logic pe_keep_data_o;
  logic [WIDTH_DATA-1:0] pe_data_i;
  logic out_valid_o;
  logic out_ready_i;
  logic [WIDTH_DATA-1:0] out_data_o;
  logic busy_o;
  modport slave (
    input cfg_len_i, in_valid_i, in_a_i, in_b_i, pe_data_i, out_ready_i,
    output in_ready_o, pe_data_a_o, pe_data_b_o, pe_format_en_o, pe_keep_data_o,
    output out_valid_o, out_data_o, busy_o
  );
  modport master (
    output cfg_len_i, in_valid_i, in_a_i, in_b_i, pe_data_i, out_ready_i,
    input in_ready_o, pe_data_a_o, pe_data_b_o, pe_format_en_o, pe_keep_data_o,
    input out_valid_o, out_data_o, busy_o
  );
endinterface

// File: rtl/pe_vector_sequencer.sv
// pe_vector_sequencer: feeds K operand pairs to a PE lane, pulses format, and buffers the formatted result
module pe_vector_sequencer #(
  parameter int WIDTH_DATA = 16,
  parameter int WIDTH_LEN = 8,
  parameter int RESULT_LAT = 3
) (
  input logic clk,
  input logic rst,
  pe_vector_sequencer_if.slave bus
);
  localparam int WW = $clog2(RESULT_LAT + 1);
  typedef enum logic [2:0] {IDLE, ACCUM, LAST, FMT, WAIT} state_t;
  state_t state, state_nx;
  logic [WIDTH_LEN-1:0] len, cnt, cfg_k;
  logic [WW-1:0] wcnt;
  logic [WIDTH_DATA-1:0] pe_a, pe_b, out_data;
  logic out_valid, in_ready, accept, capture;
  assign cfg_k = bus.cfg_len_i == '0 ? WIDTH_LEN'(1) : bus.cfg_len_i;
  assign in_ready = !rst && (state == IDLE ? !out_valid : state == ACCUM);
  assign accept = bus.in_valid_i && in_ready;
  assign capture = state == WAIT && wcnt == WW'(1);
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = cfg_k == WIDTH_LEN'(1) ? LAST : ACCUM;
      ACCUM: if (accept && cnt + WIDTH_LEN'(1) == len) state_nx = LAST;
      LAST: state_nx = FMT;
      FMT: state_nx = WAIT;
      WAIT: if (capture) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      len <= '0;
      cnt <= '0;
      wcnt <= '0;
      pe_a <= '0;
      pe_b <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      pe_a <= accept ? bus.in_a_i : '0;
      pe_b <= accept ? bus.in_b_i : '0;
      if (state == IDLE && accept) begin
        len <= cfg_k;
        cnt <= WIDTH_LEN'(1);
      end else if (accept) cnt <= cnt + WIDTH_LEN'(1);
      wcnt <= state == FMT ? WW'(RESULT_LAT) : state == WAIT ? wcnt - WW'(1) : wcnt;
      if (capture) begin
        out_valid <= 1'b1;
        out_data <= bus.pe_data_i;
      end else if (out_valid && bus.out_ready_i) out_valid <= 1'b0;
    end
  end
  assign bus.in_ready_o = in_ready;
  assign bus.pe_data_a_o = pe_a;
  assign bus.pe_data_b_o = pe_b;
  assign bus.pe_format_en_o = state == FMT;
  assign bus.pe_keep_data_o = 1'b0;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o = out_data;
  assign bus.busy_o = state != IDLE;
endmodule

// File: tb/tb_pe_vector_sequencer.sv
// tb_pe_vector_sequencer: directed and randomized checks of the sequencer against a vector-level reference model
module tb_pe_vector_sequencer;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_rdy = 1'b1;
  int rdy_mode = 0;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  longint pe_acc;
  logic [15:0] pd0, pd1, pd2;
  logic rst_q = 1'b0;
  bit open_v, closed_v, have_res;
  int t_last, nbeat, klen;
  longint sum;
  logic [15:0] exp_res, exp_a, exp_b;
  logic acc_v, exp_rdy;
  pe_vector_sequencer_if #(.WIDTH_DATA(16), .WIDTH_LEN(8)) bus ();
  pe_vector_sequencer #(.WIDTH_DATA(16), .WIDTH_LEN(8), .RESULT_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign bus.out_ready_i = out_rdy;
  assign bus.pe_data_i = pd2;
  always @(posedge clk) begin
    #2;
    out_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : ($urandom_range(0, 3) != 0);
  end
  function automatic longint mul(input logic [15:0] a, input logic [15:0] b);
    return longint'($signed(a)) * longint'($signed(b));
  endfunction
  always @(posedge clk) begin
    if (rst) begin
      pe_acc <= 0;
      pd0 <= '0;
      pd1 <= '0;
      pd2 <= '0;
    end else begin
      if (bus.pe_format_en_o) begin
        pd0 <= 16'((pe_acc + mul(bus.pe_data_a_o, bus.pe_data_b_o)) >>> 9);
        pe_acc <= 0;
      end else begin
        pd0 <= '0;
        pe_acc <= pe_acc + mul(bus.pe_data_a_o, bus.pe_data_b_o);
      end
      pd1 <= pd0;
      pd2 <= pd1;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", bus.in_ready_o, 0);
      if (rst_q) begin
        chk("rst_pe_a", bus.pe_data_a_o, 0);
        chk("rst_pe_b", bus.pe_data_b_o, 0);
        chk("rst_format", bus.pe_format_en_o, 0);
        chk("rst_keep", bus.pe_keep_data_o, 0);
        chk("rst_out_valid", bus.out_valid_o, 0);
        chk("rst_out_data", bus.out_data_o, 0);
        chk("rst_busy", bus.busy_o, 0);
      end
      open_v = 0;
      closed_v = 0;
      have_res = 0;
      exp_a = '0;
      exp_b = '0;
    end else begin
      exp_rdy = open_v || (!closed_v && !have_res);
      chk("in_ready", bus.in_ready_o, exp_rdy);
      chk("pe_a", bus.pe_data_a_o, exp_a);
      chk("pe_b", bus.pe_data_b_o, exp_b);
      chk("format", bus.pe_format_en_o, closed_v && cyc == t_last + 2);
      chk("keep", bus.pe_keep_data_o, 0);
      chk("busy", bus.busy_o, open_v || closed_v);
      chk("out_valid", bus.out_valid_o, have_res);
      if (have_res) chk("out_data", bus.out_data_o, exp_res);
      acc_v = bus.in_valid_i && exp_rdy;
      exp_a = acc_v ? bus.in_a_i : '0;
      exp_b = acc_v ? bus.in_b_i : '0;
      if (acc_v) begin
        if (!open_v) begin
          open_v = 1;
          nbeat = 0;
          sum = 0;
          klen = bus.cfg_len_i == 0 ? 1 : int'(bus.cfg_len_i);
        end
        nbeat++;
        sum += mul(bus.in_a_i, bus.in_b_i);
        if (nbeat == klen) begin
          open_v = 0;
          closed_v = 1;
          t_last = cyc;
          exp_res = 16'(sum >>> 9);
        end
      end
      if (have_res && bus.out_ready_i) have_res = 0;
      else if (closed_v && cyc == t_last + 2 + LAT) begin
        closed_v = 0;
        have_res = 1;
      end
    end
    rst_q = rst;
  end
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic [7:0] len);
    logic got;
    int n;
    bus.in_a_i = a;
    bus.in_b_i = b;
    bus.cfg_len_i = len;
    bus.in_valid_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      got = bus.in_ready_o;
      n++;
      @(posedge clk);
      #1;
    end while (!got && n < 200);
    chk("accept", got, 1);
    bus.in_valid_i = 1'b0;
  endtask
  task automatic wait_res(input string tag, input logic [15:0] exp);
    int n;
    n = 0;
    while (!bus.out_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.out_valid_o, 1);
    chk(tag, bus.out_data_o, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [15:0] held;
    int k;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic [15:0] held;
    int k;
    bus.in_valid_i = 1'b1;
    bus.in_a_i = 16'h1234;
    bus.in_b_i = 16'h5678;
    bus.cfg_len_i = 8'd4;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid_i = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", bus.in_ready_o, 1);
    @(posedge clk);
    #1;
    repeat (4) beat(16'h0200, 16'h0400, 8'd4);
    wait_res("basic", 16'h1000);
    beat(16'h0200, 16'h0200, 8'd3);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    beat(16'h0200, 16'h0200, 8'd3);
    beat(16'h0200, 16'h0200, 8'd3);
    wait_res("bubble", 16'h0600);
    beat(16'h0400, 16'h0400, 8'd0);
    wait_res("k0", 16'h0800);
    rdy_mode = 1;
    repeat (2) beat(16'h0200, 16'h0200, 8'd2);
    wait_res("bp", 16'h0400);
    held = bus.out_data_o;
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", bus.out_valid_o, 1);
      chk("bp_data", bus.out_data_o, held);
      chk("bp_in_ready", bus.in_ready_o, 0);
    end
    rdy_mode = 0;
    @(negedge clk);
    chk("pop_in_ready", bus.in_ready_o, 0);
    @(negedge clk);
    chk("post_pop_in_ready", bus.in_ready_o, 1);
    chk("post_pop_valid", bus.out_valid_o, 0);
    @(posedge clk);
    #1;
    repeat (2) beat(16'h0200, 16'h0200, 8'd4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("no_result", bus.out_valid_o, 0);
      chk("no_format", bus.pe_format_en_o, 0);
    end
    @(posedge clk);
    #1;
    beat(16'h0200, 16'h0200, 8'd1);
    wait_res("after_rst", 16'h0200);
    rdy_mode = 2;
    for (int v = 0; v < 40; v++) begin
      k = $urandom_range(0, 12);
      for (int i = 0; i < (k == 0 ? 1 : k); i++) begin
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
        beat(16'($urandom), 16'($urandom), i == 0 ? 8'(k) : 8'($urandom_range(0, 255)));
      end
    end
    rdy_mode = 0;
    repeat (40) @(posedge clk);
    #1;
    chk("drained_valid", bus.out_valid_o, 0);
    chk("drained_busy", bus.busy_o, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
